// File: rtl/arb8_pkg.sv
// Shared constants, FSM encoding and the rotating-priority winner search
// for the 8-way round-robin arbiter.
package arb8_pkg;

   localparam int NREQ  = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // First set request scanning ptr, ptr+1, ... with 3-bit wrap; 0 when nothing is set.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] cand;
      logic             found;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr + IDX_W'(k);
         if (!found && req[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 one-hot decoder used to expand the registered winner index.
module decoder3to8
   import arb8_pkg::*;
(
   input  logic [IDX_W-1:0] Data_in,
   output logic [NREQ-1:0]  Data_out
);

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
      assign Data_out[gi] = (Data_in == IDX_W'(gi));
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource between 8 requesters.
// Optional ARB_TIMEOUT_EN forces a release after HOLD_MAX owned cycles.
module rr_arbiter8
   import arb8_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  Req_in,
   input  logic             Done_in,
   output logic [NREQ-1:0]  Grant_out,
   output logic [IDX_W-1:0] Grant_idx,
   output logic             Grant_valid,
   output logic             Timeout_out
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             normal_rel;
   logic             force_rel;
   logic [NREQ-1:0]  dec_out;

   assign normal_rel = Done_in || !Req_in[idx_q];

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   assign force_rel   = (state_q == ST_OWN) && !normal_rel &&
                        (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
   assign Timeout_out = force_rel && !rst;
`else
   // Owner holds indefinitely; HOLD_MAX only matters with the timeout built in.
   assign force_rel   = 1'b0;
   assign Timeout_out = (HOLD_MAX < 0);
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|Req_in) begin
               idx_d   = rr_pick(Req_in, ptr_q);
               valid_d = 1'b1;
               state_d = ST_OWN;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end
         end
         default: begin
            if (normal_rel || force_rel) begin
               valid_d = 1'b0;
               ptr_d   = idx_q + 1'b1;
               state_d = ST_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   decoder3to8 u_dec (
      .Data_in  (idx_q),
      .Data_out (dec_out)
   );

   assign Grant_out   = dec_out & {NREQ{valid_q}};
   assign Grant_idx   = idx_q;
   assign Grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic compared against an owner/pointer reference model.
module tb_rr_arbiter8;

   localparam int TB_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_in = 8'h00;
   logic       done_in = 1'b0;
   logic [7:0] grant_out;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: who owns the resource, where the search starts, cycles held.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_cnt   = 0;
   logic tout_seen;
   logic exp_to;

   always #5 clk = ~clk;

   rr_arbiter8 #(.HOLD_MAX(TB_HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .Req_in      (req_in),
      .Done_in     (done_in),
      .Grant_out   (grant_out),
      .Grant_idx   (grant_idx),
      .Grant_valid (grant_valid),
      .Timeout_out (timeout_out)
   );

   function automatic logic [7:0] onehot(input int i);
      return (i < 0) ? 8'h00 : 8'(1 << i);
   endfunction

   // Drive one cycle of inputs, capture Timeout_out just before the edge, advance the model.
   task automatic step(input logic [7:0] r, input logic d, input logic rs);
      @(negedge clk);
      req_in  = r;
      done_in = d;
      rst     = rs;
      #4;
      tout_seen = timeout_out;
      exp_to = TO_EN && !rs && (m_owner >= 0) && (m_cnt == TB_HOLD - 1) && !d &&
               ((m_owner >= 0) ? r[m_owner] : 1'b0);
      @(posedge clk);
      if (rs) begin
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (m_owner < 0 && r[c]) m_owner = c;
         end
         m_cnt = 0;
      end else if (d || !r[m_owner] || exp_to) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
      end else begin
         m_cnt++;
      end
      #1;
   endtask

   task automatic test_reset();
      step(8'hFF, 1'b0, 1'b1);
      step(8'hFF, 1'b0, 1'b1);
      n_checks++;
      if (grant_valid !== 1'b0 || grant_out !== 8'h00 || grant_idx !== 3'd0 || timeout_out !== 1'b0)
         $display("FAIL reset: valid=%b out=%h idx=%0d to=%b, required 0/00/0/0",
                  grant_valid, grant_out, grant_idx, timeout_out);
      else n_pass++;
      $display("reset: valid=%b out=%h", grant_valid, grant_out);
   endtask

   task automatic test_single();
      step(8'h00, 1'b0, 1'b0);
      step(8'h04, 1'b0, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd2 || grant_out !== 8'h04)
         $display("FAIL single_grant: valid=%b idx=%0d out=%h, required 1/2/04",
                  grant_valid, grant_idx, grant_out);
      else n_pass++;
      step(8'h04, 1'b1, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b0 || grant_out !== 8'h00)
         $display("FAIL single_done: valid=%b out=%h, required 0/00", grant_valid, grant_out);
      else n_pass++;
      $display("single: req=04 granted then released");
   endtask

   task automatic test_rotate();
      step(8'hFF, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         step(8'hFF, 1'b0, 1'b0);
         n_checks++;
         if (grant_valid !== 1'b1 || grant_idx !== 3'(i % 8) || grant_out !== onehot(i % 8))
            $display("FAIL rotate_grant[%0d]: valid=%b idx=%0d out=%h, required 1/%0d/%h",
                     i, grant_valid, grant_idx, grant_out, i % 8, onehot(i % 8));
         else n_pass++;
         step(8'hFF, 1'b1, 1'b0);
         n_checks++;
         if (grant_valid !== 1'b0 || grant_out !== 8'h00)
            $display("FAIL rotate_idle[%0d]: valid=%b out=%h, required 0/00", i, grant_valid, grant_out);
         else n_pass++;
         $display("rotate: grant %0d idx=%0d", i, grant_idx);
      end
   endtask

   task automatic test_wrap();
      step(8'h00, 1'b0, 1'b1);
      step(8'h40, 1'b0, 1'b0);
      step(8'h40, 1'b1, 1'b0);
      step(8'h03, 1'b0, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_out !== 8'h01)
         $display("FAIL wrap: valid=%b idx=%0d out=%h, required 1/0/01", grant_valid, grant_idx, grant_out);
      else n_pass++;
      $display("wrap: after owner 6, req=03 -> idx=%0d", grant_idx);
   endtask

   task automatic test_withdraw();
      step(8'h00, 1'b0, 1'b1);
      step(8'h08, 1'b0, 1'b0);
      step(8'h10, 1'b0, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b0)
         $display("FAIL withdraw_release: valid=%b, required 0", grant_valid);
      else n_pass++;
      step(8'h18, 1'b0, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd4)
         $display("FAIL withdraw_ptr: valid=%b idx=%0d, required 1/4", grant_valid, grant_idx);
      else n_pass++;
      step(8'h08, 1'b1, 1'b0);
      step(8'hFF, 1'b0, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd5)
         $display("FAIL withdraw_done_single: valid=%b idx=%0d, required 1/5", grant_valid, grant_idx);
      else n_pass++;
      $display("withdraw: final idx=%0d", grant_idx);
   endtask

   task automatic test_timeout();
      int run_len;
      logic ended;
      int to_cycle;
      step(8'h00, 1'b0, 1'b1);
      run_len  = 0;
      ended    = 1'b0;
      to_cycle = -1;
      for (int c = 0; c < 130; c++) begin
         step(8'h01, 1'b0, 1'b0);
         if (tout_seen === 1'b1 && to_cycle < 0) to_cycle = run_len;
         if (!ended && grant_valid === 1'b1) run_len++;
         else if (run_len > 0) ended = 1'b1;
         n_checks++;
         if (grant_valid !== (m_owner >= 0) || grant_out !== onehot(m_owner) || tout_seen !== exp_to)
            $display("FAIL timeout_cycle[%0d]: valid=%b out=%h to=%b, required %b/%h/%b",
                     c, grant_valid, grant_out, tout_seen, m_owner >= 0, onehot(m_owner), exp_to);
         else n_pass++;
      end
      n_checks++;
      if (TO_EN ? (run_len !== TB_HOLD || to_cycle !== TB_HOLD) : (run_len < 100 || to_cycle !== -1))
         $display("FAIL timeout_hold: held=%0d timeout_at=%0d, required %s",
                  run_len, to_cycle, TO_EN ? "4 cycles, pulse on 4th" : ">=100 cycles, no pulse");
      else n_pass++;
      $display("timeout: held=%0d timeout_at=%0d", run_len, to_cycle);
   endtask

   task automatic test_reset_own();
      step(8'h00, 1'b0, 1'b1);
      step(8'h20, 1'b0, 1'b0);
      n_checks++;
      if (grant_idx !== 3'd5 || grant_valid !== 1'b1)
         $display("FAIL reset_own_grant: valid=%b idx=%0d, required 1/5", grant_valid, grant_idx);
      else n_pass++;
      step(8'h20, 1'b0, 1'b1);
      n_checks++;
      if (grant_out !== 8'h00 || grant_valid !== 1'b0)
         $display("FAIL reset_own_drop: valid=%b out=%h, required 0/00", grant_valid, grant_out);
      else n_pass++;
      step(8'hFF, 1'b0, 1'b0);
      n_checks++;
      if (grant_idx !== 3'd0 || grant_out !== 8'h01)
         $display("FAIL reset_own_regrant: idx=%0d out=%h, required 0/01", grant_idx, grant_out);
      else n_pass++;
      $display("reset_own: regrant idx=%0d", grant_idx);
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic       d, rs;
      step(8'h00, 1'b0, 1'b1);
      for (int c = 0; c < 400; c++) begin
         r  = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7))
                                          : 8'($urandom);
         if ($urandom_range(0, 7) == 0) r = 8'h00;
         d  = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 63) == 0);
         step(r, d, rs);
         n_checks++;
         if (grant_valid !== (m_owner >= 0) || grant_out !== onehot(m_owner) ||
             (m_owner >= 0 && grant_idx !== 3'(m_owner)) || tout_seen !== exp_to)
            $display("FAIL random[%0d]: req=%h done=%b rst=%b valid=%b idx=%0d out=%h to=%b, required valid=%b owner=%0d out=%h to=%b",
                     c, r, d, rs, grant_valid, grant_idx, grant_out, tout_seen,
                     m_owner >= 0, m_owner, onehot(m_owner), exp_to);
         else n_pass++;
         $display("random[%0d]: req=%h done=%b rst=%b owner=%0d", c, r, d, rs, m_owner);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_wrap();
      test_withdraw();
      test_timeout();
      test_reset_own();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
